// File: rtl/lcd1602_bus_writer_if.sv
// Byte-write handshake between an LCD1602 sequencer and the bus writer,
// bundled together with the physical HD44780 pins the writer drives.
interface lcd1602_bus_writer_if;
    logic       send_en;
    logic [7:0] send_data;
    logic       send_rs;
    logic       send_rw;
    logic       send_busy;
    logic       LCD1602_RS;
    logic       LCD1602_E;
    logic       LCD1602_RW;
    logic [7:0] LCD1602_DAT;

    modport master (
        output send_en, send_data, send_rs, send_rw,
        input  send_busy, LCD1602_RS, LCD1602_E, LCD1602_RW, LCD1602_DAT
    );

    modport slave (
        input  send_en, send_data, send_rs, send_rw,
        output send_busy, LCD1602_RS, LCD1602_E, LCD1602_RW, LCD1602_DAT
    );
endinterface

// File: rtl/lcd1602_bus_writer.sv
// HD44780 8-bit write engine: one E pulse per accepted byte with setup,
// pulse-width, hold and execution timing, plus the power-on wait after reset.
module lcd1602_bus_writer #(
    parameter int CLK_FRE   = 20,
    parameter int T_SU_NS   = 100,
    parameter int T_PW_NS   = 500,
    parameter int T_HOLD_NS = 100,
    parameter int T_EXEC_US = 40,
    parameter int T_CLR_US  = 1600,
    parameter int T_POR_MS  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    lcd1602_bus_writer_if.slave  bus
);

    function automatic int cycles_ceil(input int num, input int den);
        int c;
        c = (num + den - 1) / den;
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int N_SU   = cycles_ceil(T_SU_NS * CLK_FRE, 1000);
    localparam int N_PW   = cycles_ceil(T_PW_NS * CLK_FRE, 1000);
    localparam int N_HOLD = cycles_ceil(T_HOLD_NS * CLK_FRE, 1000);
    localparam int N_EXEC = cycles_ceil(T_EXEC_US * CLK_FRE, 1);
    localparam int N_CLR  = cycles_ceil(T_CLR_US * CLK_FRE, 1);
    localparam int N_POR  = cycles_ceil(T_POR_MS * 1000 * CLK_FRE, 1);
    localparam int N_MAX  = max2(max2(max2(N_SU, N_PW), max2(N_HOLD, N_EXEC)), max2(N_CLR, N_POR));
    localparam int CNT_W  = max2($clog2(N_MAX), 1);

    localparam logic [CNT_W-1:0] LAST_SU   = CNT_W'(N_SU - 1);
    localparam logic [CNT_W-1:0] LAST_PW   = CNT_W'(N_PW - 1);
    localparam logic [CNT_W-1:0] LAST_HOLD = CNT_W'(N_HOLD - 1);
    localparam logic [CNT_W-1:0] LAST_EXEC = CNT_W'(N_EXEC - 1);
    localparam logic [CNT_W-1:0] LAST_CLR  = CNT_W'(N_CLR - 1);
    localparam logic [CNT_W-1:0] LAST_POR  = CNT_W'(N_POR - 1);

    typedef enum logic [2:0] {
        ST_POR,
        ST_IDLE,
        ST_SETUP,
        ST_EHIGH,
        ST_HOLD,
        ST_EXEC
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q;
    logic             e_q;
    logic             rs_q;
    logic             rw_q;
    logic [7:0]       dat_q;
    logic             long_q;
    logic             accept;

    assign accept = (state_q == ST_IDLE) && bus.send_en;

    // cnt_q counts the cycles already spent in the current state and is cleared
    // on every state entry, so each state lasts exactly its N_* cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        unique case (state_q)
            ST_POR: begin
                if (cnt_q == LAST_POR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.send_en) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == LAST_SU) begin
                    state_d = ST_EHIGH;
                    cnt_d   = '0;
                end
            end
            ST_EHIGH: begin
                if (cnt_q == LAST_PW) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == LAST_HOLD) begin
                    state_d = ST_EXEC;
                    cnt_d   = '0;
                end
            end
            ST_EXEC: begin
                if (cnt_q == (long_q ? LAST_CLR : LAST_EXEC)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_POR;
                cnt_d   = '0;
            end
        endcase
    end

    // busy and E are registered from the next state so both pins are glitch-free
    // and line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_POR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            dat_q   <= 8'h00;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != ST_IDLE);
            e_q     <= (state_d == ST_EHIGH);
            if (accept) begin
                rs_q   <= bus.send_rs;
                rw_q   <= bus.send_rw;
                dat_q  <= bus.send_data;
                long_q <= !bus.send_rs && (bus.send_data inside {8'h01, 8'h02, 8'h03});
            end
        end
    end

    assign bus.send_busy   = busy_q;
    assign bus.LCD1602_E   = e_q;
    assign bus.LCD1602_RS  = rs_q;
    assign bus.LCD1602_RW  = rw_q;
    assign bus.LCD1602_DAT = dat_q;

endmodule

// File: tb/tb_lcd1602_bus_writer.sv
// Randomized scoreboard bench for lcd1602_bus_writer: stimulus pushes expected
// transfers, an independent pin monitor pops and checks each E pulse and busy window.
module tb_lcd1602_bus_writer;

    localparam int CLK_FRE   = 20;
    localparam int T_SU_NS   = 100;
    localparam int T_PW_NS   = 500;
    localparam int T_HOLD_NS = 100;
    localparam int T_EXEC_US = 40;
    localparam int T_CLR_US  = 100;
    localparam int T_POR_MS  = 1;

    // Expected cycle counts straight from the timing parameters (all exceed 1 here).
    localparam int E_SU   = (T_SU_NS * CLK_FRE + 999) / 1000;
    localparam int E_PW   = (T_PW_NS * CLK_FRE + 999) / 1000;
    localparam int E_HOLD = (T_HOLD_NS * CLK_FRE + 999) / 1000;
    localparam int E_EXEC = T_EXEC_US * CLK_FRE;
    localparam int E_CLR  = T_CLR_US * CLK_FRE;
    localparam int E_POR  = T_POR_MS * 1000 * CLK_FRE;

    typedef struct {
        logic [7:0] data;
        logic       rs;
        logic       rw;
        int         window;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    txn_t exp_q[$];

    lcd1602_bus_writer_if bus_if ();

    lcd1602_bus_writer #(
        .CLK_FRE  (CLK_FRE),
        .T_SU_NS  (T_SU_NS),
        .T_PW_NS  (T_PW_NS),
        .T_HOLD_NS(T_HOLD_NS),
        .T_EXEC_US(T_EXEC_US),
        .T_CLR_US (T_CLR_US),
        .T_POR_MS (T_POR_MS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, want %0d", name, act, req);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s: event occurred, want none", name);
    endtask

    // Reference model: clear display / return home (commands 0x01..0x03) wait long.
    function automatic int model_window(input logic [7:0] d, input logic rs);
        bit is_long;
        is_long = (rs == 1'b0) && (d >= 8'h01) && (d <= 8'h03);
        return E_SU + E_PW + E_HOLD + (is_long ? E_CLR : E_EXEC);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    txn_t cur;
    bit   in_txn = 0;
    bit   first  = 0;
    bit   pins_ok;
    int   busy_len, e_len, e_pulses;
    logic e_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            in_txn = 0;
            exp_q.delete();
        end else begin
            if (in_txn) begin
                if (first) begin
                    check("busy_rise", bus_if.send_busy, 1);
                    first = 0;
                end
                if (bus_if.send_busy) busy_len++;
                if (bus_if.LCD1602_E && !e_prev) begin
                    e_pulses++;
                    if (e_pulses == 1) begin
                        check("e_rise_cycle", busy_len, E_SU + 1);
                        check("dat_at_e", bus_if.LCD1602_DAT, cur.data);
                        check("rs_at_e", bus_if.LCD1602_RS, cur.rs);
                        check("rw_at_e", bus_if.LCD1602_RW, cur.rw);
                    end
                end
                if (bus_if.LCD1602_E) e_len++;
                if (bus_if.LCD1602_DAT !== cur.data || bus_if.LCD1602_RS !== cur.rs ||
                    bus_if.LCD1602_RW !== cur.rw) pins_ok = 0;
                if (!bus_if.send_busy) begin
                    in_txn = 0;
                    check("busy_window", busy_len, cur.window);
                    check("e_width", e_len, E_PW);
                    check("e_pulses", e_pulses, 1);
                    check("pins_stable", pins_ok, 1);
                    $display("txn data=0x%02h rs=%0d rw=%0d busy=%0d e_width=%0d",
                             cur.data, cur.rs, cur.rw, busy_len, e_len);
                end
            end else begin
                if (bus_if.LCD1602_E) fail_now("e_outside_transfer");
            end
            if (!in_txn && bus_if.send_en && !bus_if.send_busy) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_accept");
                end else begin
                    cur      = exp_q.pop_front();
                    in_txn   = 1;
                    first    = 1;
                    busy_len = 0;
                    e_len    = 0;
                    e_pulses = 0;
                    pins_ok  = 1;
                end
            end
        end
        e_prev = bus_if.LCD1602_E;
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int n = 0;
        while (bus_if.send_busy && n < 40000) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus_if.send_busy) fail_now("idle_timeout");
    endtask

    task automatic por_check(input string tag);
        int n = 0;
        bit e_low = 1;
        while (bus_if.send_busy && n < E_POR + 100) begin
            if (bus_if.LCD1602_E) e_low = 0;
            bus_if.send_en = (n == 50);
            n++;
            @(posedge clk); #1;
        end
        bus_if.send_en = 1'b0;
        check({tag, "_por_cycles"}, n, E_POR);
        check({tag, "_por_e_low"}, e_low, 1);
    endtask

    task automatic send(input logic [7:0] d, input logic rs, input logic rw, input int pokes);
        wait_idle();
        bus_if.send_data = d;
        bus_if.send_rs   = rs;
        bus_if.send_rw   = rw;
        bus_if.send_en   = 1'b1;
        exp_q.push_back('{data: d, rs: rs, rw: rw, window: model_window(d, rs)});
        @(posedge clk); #1;
        bus_if.send_en = 1'b0;
        for (int p = 0; p < pokes; p++) begin
            repeat ($urandom_range(1, 300)) @(posedge clk);
            #1;
            if (bus_if.send_busy) begin
                bus_if.send_en   = 1'b1;
                bus_if.send_data = 8'($urandom);
                bus_if.send_rs   = 1'($urandom);
                @(posedge clk); #1;
                bus_if.send_en = 1'b0;
            end
        end
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] d;
        logic       rs;
        int         r;

        bus_if.send_en   = 1'b0;
        bus_if.send_data = 8'h00;
        bus_if.send_rs   = 1'b0;
        bus_if.send_rw   = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus_if.send_busy, 1);
        check("rst_e", bus_if.LCD1602_E, 0);
        check("rst_dat", bus_if.LCD1602_DAT, 0);
        check("rst_rs", bus_if.LCD1602_RS, 0);
        check("rst_rw", bus_if.LCD1602_RW, 0);
        rst = 1'b0;
        por_check("boot");

        // Directed: character, clear, 0x01 as data, set-DDRAM, home/entry boundaries.
        send(8'h41, 1'b1, 1'b0, 3);
        send(8'h01, 1'b0, 1'b0, 2);
        send(8'h01, 1'b1, 1'b0, 0);
        send(8'h80, 1'b0, 1'b0, 0);
        send(8'h02, 1'b0, 1'b0, 0);
        send(8'h03, 1'b0, 1'b0, 0);
        send(8'h04, 1'b0, 1'b1, 0);
        send(8'h00, 1'b0, 1'b0, 1);

        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0) begin
                d  = 8'($urandom_range(0, 4));
                rs = 1'b0;
            end else begin
                d  = 8'($urandom);
                rs = 1'($urandom);
            end
            send(d, rs, 1'($urandom), $urandom_range(0, 2));
        end

        // Reset while E is high: pins drop on the reset edge, POR repeats.
        send(8'h55, 1'b1, 1'b0, 0);
        n = 0;
        while (!bus_if.LCD1602_E && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("e_high_before_rst", bus_if.LCD1602_E, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_e", bus_if.LCD1602_E, 0);
        check("midrst_dat", bus_if.LCD1602_DAT, 0);
        check("midrst_busy", bus_if.send_busy, 1);
        rst = 1'b0;
        por_check("midrst");

        send(8'h30, 1'b1, 1'b0, 0);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size() + int'(in_txn), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
